risc_step_controller: RTL
=========================

// Module: risc_step_controller
// PURPOSE
//  Execution sequencer for the RISC-V core under VGA debug. Turns board switches into a
//  core clock-enable: halt, free-run (slowed so the display stays readable), single-step,
//  and a PC breakpoint. Sits between the switch inputs and the core. ce_count feeds the
//  debug display's clock_counter.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  cycles an input must be stable before acceptance (10 ms @ 50 MHz)
//  RUN_DIV          1       RUN issues one core_ce every RUN_DIV cycles; must be >= 1
// PORTS
//  clock      in   1   50 MHz system clock, single clock domain
//  sw0        in   1   reset, asynchronous, active-high
//  run_sw     in   1   raw switch: 1 = run, 0 = halt
//  step_btn   in   1   raw button: each debounced rising edge requests one step
//  bp_en_sw   in   1   raw switch: breakpoint enable
//  bp_addr    in   32  breakpoint PC, synchronous to clock
//  pc         in   32  PC of the next instruction the core will execute
//  core_ce    out  1   core clock-enable; one high cycle executes one instruction
//  state      out  2   00 HALT, 01 RUN, 10 STEP, 11 BREAK
//  halted     out  1   1 in HALT or BREAK
//  bp_hit     out  1   1 while in BREAK
//  ce_count   out  32  count of core_ce cycles, wraps 0xFFFFFFFF -> 0
// BEHAVIOUR
//  - Reset: state=HALT, core_ce=0, halted=1, bp_hit=0, ce_count=0, divider=0,
//    sync/debounce flops=0. Reset in any state, including mid-divide or mid-STEP,
//    drops core_ce asynchronously and no step is pending afterwards.
//  - Raw inputs pass a 2-flop synchronizer, then a debouncer. The debounced value changes
//    only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles.
//    Any mismatch gap restarts the count.
//  - step_rise is a 1-cycle pulse on a debounced step_btn 0->1. Holding the button gives
//    exactly one pulse.
//  - Input-to-action latency: 2 sync + DEBOUNCE_CYCLES + 1 registered FSM cycle.
//  - HALT: core_ce=0.
//      run_db=1 -> RUN, with divider cleared.
//      else step_rise -> STEP.
//      If both occur in one cycle, run wins and the step is discarded.
//  - STEP: core_ce=1 for exactly one cycle, then -> HALT.
//      No breakpoint check in STEP, so stepping off a breakpoint works.
//  - RUN: divider counts 0..RUN_DIV-1 and wraps. Issue point is div==RUN_DIV-1
//    (every cycle when RUN_DIV=1). Priority at the issue point:
//      1. run_db=0 -> HALT, core_ce=0.
//      2. bp_en_db=1 and pc==bp_addr -> BREAK, core_ce=0.
//         The breakpoint instruction is not executed.
//      3. otherwise core_ce=1.
//    At a non-issue point, run_db=0 -> HALT.
//  - BREAK: core_ce=0, bp_hit=1.
//      run_db=0 -> HALT.
//      step_rise -> STEP (executes the breakpoint instruction, then HALT; if run_db is
//      still 1, RUN resumes from the next PC).
//      Both in one cycle -> HALT.
//  - ce_count increments in every cycle where core_ce=1 (registered, visible next cycle).
//  - core_ce, state, halted and bp_hit are decoded combinationally from the state register
//    and divider; no input reaches them combinationally except pc and bp_addr (RUN issue).
// CONFIGURATION
//  RISC_STEP_SNAPSHOT_EN defined:
//    - Adds port instruction in 32.
//    - Adds ports snap_pc out 32 and snap_instr out 32.
//    - On every core_ce=1 cycle, pc and instruction are latched, visible the next cycle.
//    - Reset value 0. Holds value while halted, giving the display the last executed
//      instruction.
//  RISC_STEP_SNAPSHOT_EN undefined: those ports and registers do not exist; all else identical.
// TESTING  (DEBOUNCE_CYCLES=4, RUN_DIV=3 unless noted)
//  1. Reset, all inputs 0 -> state=00, halted=1, core_ce=0, ce_count=0 for 20 cycles.
//  2. step_btn high 12 cycles -> exactly one core_ce pulse, state 10 then 00, ce_count=1.
//  3. step_btn high 2 cycles, then low -> no core_ce, state stays 00.
//  4. run_sw=1 held -> state 01; core_ce every 3rd cycle; 30 cycles in RUN -> ce_count=10.
//     run_sw=0 -> state 00 after debounce, no further core_ce.
//  5. bp_en_sw=1, bp_addr=0x1008, run_sw=1, bench advances pc by 4 per core_ce from 0x1000
//     -> two pulses, then state=11, bp_hit=1, no pulse at pc=0x1008.
//     step -> one pulse, pc=0x100C, RUN resumes.
//  6. sw0 pulsed mid-divide in RUN -> core_ce=0 immediately, state=00, ce_count=0.
//     Same for ce_count=0xFFFFFFFF pre-loaded via force: next ce -> 0.

Source files
------------

// File: rtl/risc_step_controller.sv
// Execution sequencer: debounced switches drive a core clock-enable (halt/run/step/breakpoint).
// Optional PC/instruction snapshot of the last executed instruction under RISC_STEP_SNAPSHOT_EN.
module risc_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 1
) (
  input  logic        clock,
  input  logic        sw0,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        bp_en_sw,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
`ifdef RISC_STEP_SNAPSHOT_EN
  input  logic [31:0] instruction,
  output logic [31:0] snap_pc,
  output logic [31:0] snap_instr,
`endif
  output logic        core_ce,
  output logic [1:0]  state,
  output logic        halted,
  output logic        bp_hit,
  output logic [31:0] ce_count
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_e;

  // bit 0 run, bit 1 step, bit 2 breakpoint enable
  logic [2:0]            raw_s;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            db_q, db_d;
  logic [2:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic                  step_prev_q;
  logic                  run_db_s, bp_en_db_s, step_rise_s;
  logic                  issue_s, bp_match_s;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [31:0]           ce_count_q, ce_count_d;

  assign raw_s       = {bp_en_sw, step_btn, run_sw};
  assign run_db_s    = db_q[0];
  assign bp_en_db_s  = db_q[2];
  assign step_rise_s = db_q[1] & ~step_prev_q;
  assign issue_s     = (div_q == DIV_LAST);
  assign bp_match_s  = bp_en_db_s & (pc == bp_addr);

  always_ff @(posedge clock or posedge sw0) begin
    if (sw0) begin
      sync1_q     <= 3'b000;
      sync2_q     <= 3'b000;
      db_q        <= 3'b000;
      db_cnt_q    <= '0;
      step_prev_q <= 1'b0;
    end else begin
      sync1_q     <= raw_s;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      step_prev_q <= db_q[1];
    end
  end

  // A single matching cycle clears the count, so only an unbroken mismatch run is accepted.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == CNT_LAST) begin
          db_d[i]     = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge sw0) begin
    if (sw0) begin
      state_q    <= S_HALT;
      div_q      <= '0;
      ce_count_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      ce_count_q <= ce_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    case (state_q)
      S_HALT: begin
        if (run_db_s)         state_d = S_RUN;
        else if (step_rise_s) state_d = S_STEP;
        else                  state_d = S_HALT;
      end
      S_STEP: state_d = S_HALT;
      S_RUN: begin
        if (!run_db_s) begin
          state_d = S_HALT;
        end else if (issue_s && bp_match_s) begin
          state_d = S_BREAK;
        end else begin
          state_d = S_RUN;
          div_d   = issue_s ? '0 : div_q + DIV_W'(1);
        end
      end
      // Run switch off beats a step request here.
      S_BREAK: begin
        if (!run_db_s)        state_d = S_HALT;
        else if (step_rise_s) state_d = S_STEP;
        else                  state_d = S_BREAK;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    core_ce = 1'b0;
    halted  = 1'b0;
    bp_hit  = 1'b0;
    case (state_q)
      S_HALT:  halted  = 1'b1;
      S_STEP:  core_ce = 1'b1;
      S_RUN:   core_ce = issue_s & run_db_s & ~bp_match_s;
      S_BREAK: begin
        halted = 1'b1;
        bp_hit = 1'b1;
      end
      default: halted = 1'b1;
    endcase
  end

  assign state      = state_q;
  assign ce_count   = ce_count_q;
  assign ce_count_d = ce_count_q + {31'd0, core_ce};

`ifdef RISC_STEP_SNAPSHOT_EN
  logic [31:0] snap_pc_q, snap_pc_d;
  logic [31:0] snap_instr_q, snap_instr_d;

  always_ff @(posedge clock or posedge sw0) begin
    if (sw0) begin
      snap_pc_q    <= 32'd0;
      snap_instr_q <= 32'd0;
    end else begin
      snap_pc_q    <= snap_pc_d;
      snap_instr_q <= snap_instr_d;
    end
  end

  always_comb begin
    if (core_ce) begin
      snap_pc_d    = pc;
      snap_instr_d = instruction;
    end else begin
      snap_pc_d    = snap_pc_q;
      snap_instr_d = snap_instr_q;
    end
  end

  assign snap_pc    = snap_pc_q;
  assign snap_instr = snap_instr_q;
`endif

endmodule
